ipsmacge_lbctrl: RTL and testbench
==================================

// Module: ipsmacge_lbctrl
// PURPOSE
//  Loopback mode sequencer for the GE MAC loopback pair (loopback-in / loopback-out FIFOs).
//  Turns CPU loopback requests into glitch-free uplbin/uplbout/ffnum/flush controls:
//  waits for an inter-frame gap, flushes the FIFOs, then switches mode.
//  Enforces one loopback mode at a time. Counts FIFO over/underrun pulses for status.
// PARAMETERS
//  GAP_CYC  12    consecutive idle cycles (frm_act=0) required before a mode switch
//  FSH_CYC  4     cycles the FIFO flush strobe is held
//  TMO_CYC  4096  max cycles waiting for a gap before a forced switch
//  CNT_W    8     width of the saturating error counters
// PORTS
//  clk           in   1      block clock
//  rst           in   1      synchronous reset, active high
//  cfg_lbin_req  in   1      CPU request: loopback-in mode (level)
//  cfg_lbout_req in   1      CPU request: loopback-out mode (level)
//  cfg_ffnum     in   4      FIFO threshold to apply at the next switch
//  cfg_flush_req in   1      one-cycle pulse: flush the FIFOs without a mode change
//  frm_act       in   1      frame in progress on the gated path (en|dv, already in clk domain)
//  lbi_err       in   1      lbin FIFO wr/rd error pulse (synced, OR of both)
//  lbo_err       in   1      lbout FIFO wr/rd error pulse (synced, OR of both)
//  err_clr       in   1      pulse: clear counters and sticky flags
//  uplbin        out  1      loopback-in enable
//  uplbout       out  1      loopback-out enable
//  uplbinffnum   out  4      lbin FIFO threshold
//  uplboutffnum  out  4      lbout FIFO threshold
//  uplbinfffsh   out  1      lbin FIFO flush
//  uplboutfffsh  out  1      lbout FIFO flush
//  lb_state      out  2      0 NORM, 1 WGAP, 2 FLSH, 3 ACT
//  lb_busy       out  1      state is WGAP or FLSH
//  lb_conflict   out  1      sticky: both requests were high together
//  lb_tmo        out  1      sticky: a switch was forced by timeout
//  errcnt_lbi    out  CNT_W  saturating count of lbi_err
//  errcnt_lbo    out  CNT_W  saturating count of lbo_err
// BEHAVIOUR
//  Reset: state NORM, cur_mode = tgt_mode = NONE, every output 0, all counters 0.
//  req_mode = LBIN if cfg_lbin_req, else LBOUT if cfg_lbout_req, else NONE
//   (lbin has priority). Both high -> lb_conflict set.
//  NORM/ACT: req_mode != cur_mode -> tgt_mode <= req_mode, go to WGAP.
//   A cfg_flush_req pulse -> tgt_mode <= cur_mode, go to WGAP. In WGAP/FLSH the pulse is dropped.
//  WGAP: gap_cnt increments while frm_act=0 and resets to 0 when frm_act=1.
//   tmo_cnt increments every cycle. tgt_mode re-latches from req_mode every cycle.
//   If req_mode returns to cur_mode and no flush is pending -> back to NORM/ACT with no flush.
//   gap_cnt == GAP_CYC-1 with frm_act=0 -> FLSH.
//   Else tmo_cnt == TMO_CYC-1 -> FLSH and set lb_tmo.
//  FLSH: uplbin = uplbout = 0 for the whole state.
//   Both fffsh outputs = 1 for exactly FSH_CYC cycles.
//   ffnum outputs load cfg_ffnum on the FLSH entry cycle. They are stable at all other times.
//   On exit: cur_mode <= tgt_mode. Next state is NORM if NONE, else ACT.
//  ACT: the uplb* bit for cur_mode = 1, the other = 0. Never both 1.
//  Enables change only on FLSH entry and exit, so latency from a request edge is
//   at least GAP_CYC+FSH_CYC+1 and at most TMO_CYC+FSH_CYC+1 cycles.
//  Error counters: +1 per pulse, saturate at 2^CNT_W-1 with no wrap.
//   err_clr wins over a coincident pulse (result 0). err_clr also clears lb_conflict and lb_tmo.
//  Synchronous reset mid-FLSH or mid-WGAP: immediately NORM, enables 0, flush 0.
//  All outputs are registered.
// STRUCTURE
//  ipsmacge_lbctrl_def.vh: state codes (NORM/WGAP/FLSH/ACT), mode codes (NONE/LBIN/LBOUT).
//  Sub-module ipsmacge_satcnt #(CNT_W) (inc, clr -> cnt), instantiated twice for the error counters.
//  FSM, gap/timeout/flush counters and output registers live inline.
// TESTING
//  Reset, then cfg_lbin_req=1 with frm_act=0
//   -> FLSH entered after 12 cycles, fffsh both high 4 cycles, then uplbin=1, lb_state=3.
//  frm_act toggles busy every 10 cycles while switching lbin->lbout
//   -> never switches. At cycle 4095 -> forced FLSH, lb_tmo=1, then uplbout=1, uplbin=0.
//  Both reqs high -> uplbin=1 only, lb_conflict=1. err_clr -> lb_conflict=0.
//  In ACT, req drops for 5 cycles then returns during WGAP
//   -> back to ACT, no flush pulse, uplbin remains 1.
//  300 lbi_err pulses -> errcnt_lbi=255. err_clr coincident with a pulse -> errcnt_lbi=0.
//  rst asserted in 2nd FLSH cycle -> next cycle: all outputs 0, lb_state=0.

Source files
------------

// File: rtl/ipsmacge_lbctrl_pkg.sv
// Shared state/mode encodings and small decode helpers for the GE MAC loopback sequencer.
package ipsmacge_lbctrl_pkg;

    typedef enum logic [1:0] {
        StNorm = 2'd0,
        StWgap = 2'd1,
        StFlsh = 2'd2,
        StAct  = 2'd3
    } lb_state_e;

    typedef enum logic [1:0] {
        ModeNone  = 2'd0,
        ModeLbin  = 2'd1,
        ModeLbout = 2'd2
    } lb_mode_e;

    // Loopback-in wins when both requests are raised.
    function automatic lb_mode_e decode_req(input logic lbin, input logic lbout);
        if (lbin) begin
            return ModeLbin;
        end
        if (lbout) begin
            return ModeLbout;
        end
        return ModeNone;
    endfunction

    // Returns {uplbin, uplbout}; never both set.
    function automatic logic [1:0] mode_enables(input lb_mode_e mode);
        case (mode)
            ModeLbin:  return 2'b10;
            ModeLbout: return 2'b01;
            default:   return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/ipsmacge_lbctrl_satcnt.sv
// Saturating event counter; clear has priority over a coincident increment.
module ipsmacge_lbctrl_satcnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ipsmacge_lbctrl.sv
// Loopback mode sequencer: waits for an inter-frame gap (or timeout), flushes both
// loopback FIFOs, then applies the requested mode. All outputs come straight from flops.
module ipsmacge_lbctrl
    import ipsmacge_lbctrl_pkg::*;
#(
    parameter int unsigned GAP_CYC = 12,
    parameter int unsigned FSH_CYC = 4,
    parameter int unsigned TMO_CYC = 4096,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_lbin_req_i,
    input  logic             cfg_lbout_req_i,
    input  logic [3:0]       cfg_ffnum_i,
    input  logic             cfg_flush_req_i,
    input  logic             frm_act_i,
    input  logic             lbi_err_i,
    input  logic             lbo_err_i,
    input  logic             err_clr_i,
    output logic             uplbin_o,
    output logic             uplbout_o,
    output logic [3:0]       uplbinffnum_o,
    output logic [3:0]       uplboutffnum_o,
    output logic             uplbinfffsh_o,
    output logic             uplboutfffsh_o,
    output logic [1:0]       lb_state_o,
    output logic             lb_busy_o,
    output logic             lb_conflict_o,
    output logic             lb_tmo_o,
    output logic [CNT_W-1:0] errcnt_lbi_o,
    output logic [CNT_W-1:0] errcnt_lbo_o
);

    localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int unsigned FshW = (FSH_CYC > 1) ? $clog2(FSH_CYC) : 1;
    localparam int unsigned TmoW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYC - 1);
    localparam logic [FshW-1:0] FshLast = FshW'(FSH_CYC - 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TMO_CYC - 1);

    lb_state_e       state_q;
    lb_mode_e        cur_mode_q, tgt_mode_q, req_mode;
    logic [GapW-1:0] gap_cnt_q;
    logic [FshW-1:0] fsh_cnt_q;
    logic [TmoW-1:0] tmo_cnt_q;
    logic            flush_pend_q;
    logic            uplbin_q, uplbout_q, fffsh_q, busy_q, conflict_q, tmo_q;
    logic [3:0]      ffnum_q;
    logic            gap_hit, tmo_hit;

    assign req_mode = decode_req(cfg_lbin_req_i, cfg_lbout_req_i);
    assign gap_hit  = !frm_act_i && (gap_cnt_q == GapLast);
    assign tmo_hit  = (tmo_cnt_q == TmoLast);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StNorm;
            cur_mode_q   <= ModeNone;
            tgt_mode_q   <= ModeNone;
            gap_cnt_q    <= '0;
            fsh_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            uplbin_q     <= 1'b0;
            uplbout_q    <= 1'b0;
            fffsh_q      <= 1'b0;
            ffnum_q      <= '0;
            busy_q       <= 1'b0;
            conflict_q   <= 1'b0;
            tmo_q        <= 1'b0;
        end else begin
            if (err_clr_i) begin
                conflict_q <= 1'b0;
            end else if (cfg_lbin_req_i && cfg_lbout_req_i) begin
                conflict_q <= 1'b1;
            end

            unique case (state_q)
                StNorm, StAct: begin
                    if ((req_mode != cur_mode_q) || cfg_flush_req_i) begin
                        state_q      <= StWgap;
                        busy_q       <= 1'b1;
                        tgt_mode_q   <= req_mode;
                        flush_pend_q <= cfg_flush_req_i;
                        gap_cnt_q    <= '0;
                        tmo_cnt_q    <= '0;
                    end
                end
                StWgap: begin
                    tgt_mode_q <= req_mode;
                    if ((req_mode == cur_mode_q) && !flush_pend_q) begin
                        // Request withdrawn before the gap: resume without touching the FIFOs.
                        state_q <= (cur_mode_q == ModeNone) ? StNorm : StAct;
                        busy_q  <= 1'b0;
                    end else if (gap_hit || tmo_hit) begin
                        if (!gap_hit) begin
                            tmo_q <= 1'b1;
                        end
                        state_q      <= StFlsh;
                        uplbin_q     <= 1'b0;
                        uplbout_q    <= 1'b0;
                        fffsh_q      <= 1'b1;
                        ffnum_q      <= cfg_ffnum_i;
                        fsh_cnt_q    <= '0;
                        flush_pend_q <= 1'b0;
                    end else begin
                        gap_cnt_q <= frm_act_i ? '0 : gap_cnt_q + 1'b1;
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                StFlsh: begin
                    if (fsh_cnt_q == FshLast) begin
                        cur_mode_q              <= tgt_mode_q;
                        fffsh_q                 <= 1'b0;
                        busy_q                  <= 1'b0;
                        {uplbin_q, uplbout_q}   <= mode_enables(tgt_mode_q);
                        state_q <= (tgt_mode_q == ModeNone) ? StNorm : StAct;
                    end else begin
                        fsh_cnt_q <= fsh_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase

            if (err_clr_i) begin
                tmo_q <= 1'b0;
            end
        end
    end

    ipsmacge_lbctrl_satcnt #(
        .CNT_W (CNT_W)
    ) u_cnt_lbi (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (lbi_err_i),
        .clr_i (err_clr_i),
        .cnt_o (errcnt_lbi_o)
    );

    ipsmacge_lbctrl_satcnt #(
        .CNT_W (CNT_W)
    ) u_cnt_lbo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (lbo_err_i),
        .clr_i (err_clr_i),
        .cnt_o (errcnt_lbo_o)
    );

    assign uplbin_o       = uplbin_q;
    assign uplbout_o      = uplbout_q;
    assign uplbinffnum_o  = ffnum_q;
    assign uplboutffnum_o = ffnum_q;
    assign uplbinfffsh_o  = fffsh_q;
    assign uplboutfffsh_o = fffsh_q;
    assign lb_state_o     = state_q;
    assign lb_busy_o      = busy_q;
    assign lb_conflict_o  = conflict_q;
    assign lb_tmo_o       = tmo_q;

endmodule

// File: tb/tb_ipsmacge_lbctrl.sv
// Self-checking bench for ipsmacge_lbctrl: mode switching, timeout, conflict, abort,
// flush, error counters and reset during flush.
module tb_ipsmacge_lbctrl;

    localparam int GAP = 12;
    localparam int FSH = 4;
    localparam int TMO = 4096;
    localparam int CW  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          lbin_req, lbout_req, flush_req, frm_act, lbi_err, lbo_err, err_clr;
    logic [3:0]    cfg_ffnum;
    logic          uplbin, uplbout, fsh_in, fsh_out, busy, conflict, tmo;
    logic [3:0]    ffnum_in, ffnum_out;
    logic [1:0]    lb_state;
    logic [CW-1:0] errcnt_lbi, errcnt_lbo;

    typedef struct {
        string       tag;
        int unsigned exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    always #5 clk = ~clk;

    ipsmacge_lbctrl #(
        .GAP_CYC (GAP),
        .FSH_CYC (FSH),
        .TMO_CYC (TMO),
        .CNT_W   (CW)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cfg_lbin_req_i  (lbin_req),
        .cfg_lbout_req_i (lbout_req),
        .cfg_ffnum_i     (cfg_ffnum),
        .cfg_flush_req_i (flush_req),
        .frm_act_i       (frm_act),
        .lbi_err_i       (lbi_err),
        .lbo_err_i       (lbo_err),
        .err_clr_i       (err_clr),
        .uplbin_o        (uplbin),
        .uplbout_o       (uplbout),
        .uplbinffnum_o   (ffnum_in),
        .uplboutffnum_o  (ffnum_out),
        .uplbinfffsh_o   (fsh_in),
        .uplboutfffsh_o  (fsh_out),
        .lb_state_o      (lb_state),
        .lb_busy_o       (busy),
        .lb_conflict_o   (conflict),
        .lb_tmo_o        (tmo),
        .errcnt_lbi_o    (errcnt_lbi),
        .errcnt_lbo_o    (errcnt_lbo)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    // Follows one switch from the first WGAP cycle through FLSH, measuring its phases.
    task automatic run_switch(input bit toggle, output int wgap_n, output int flsh_n,
                              output int fsh_n, output bit en_in_flsh, output bit en_moved,
                              output logic [3:0] ffnum_at_flsh);
        logic [1:0] en0;
        int         k;
        en0 = {uplbin, uplbout};
        k = 0;
        wgap_n = 0;
        flsh_n = 0;
        fsh_n = 0;
        en_in_flsh = 1'b0;
        en_moved = 1'b0;
        while (lb_state == 2'd1 && k < TMO + 200) begin
            wgap_n++;
            if ({uplbin, uplbout} !== en0) en_moved = 1'b1;
            if (toggle) frm_act = ((k / 10) % 2) == 0;
            step();
            k++;
        end
        frm_act = 1'b0;
        ffnum_at_flsh = ffnum_in;
        while (lb_state == 2'd2 && k < TMO + 200) begin
            flsh_n++;
            if (fsh_in === 1'b1 && fsh_out === 1'b1) fsh_n++;
            if (uplbin !== 1'b0 || uplbout !== 1'b0) en_in_flsh = 1'b1;
            step();
            k++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {lbin_req, lbout_req, flush_req, frm_act, lbi_err, lbo_err, err_clr} = '0;
        cfg_ffnum = 4'h0;
        step();
        step();
        n_cmp++;
        if (lb_state !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_state got=%0d exp=0", lb_state);
        end
        n_cmp++;
        if ({uplbin, uplbout, fsh_in, fsh_out, busy} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctl got=%b exp=00000", {uplbin, uplbout, fsh_in, fsh_out, busy});
        end
        n_cmp++;
        if ({ffnum_in, ffnum_out} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_ffnum got=%h exp=00", {ffnum_in, ffnum_out});
        end
        n_cmp++;
        if ({conflict, tmo, errcnt_lbi, errcnt_lbo} !== '0) begin
            n_bad++;
            $display("FAIL reset_status got=%b%b %0d %0d exp=00 0 0", conflict, tmo,
                     errcnt_lbi, errcnt_lbo);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_lbin_switch();
        int         wg, fl, fs;
        bit         en_fl, moved;
        logic [3:0] ffn;
        sb_t        e;
        cfg_ffnum = 4'hA;
        lbin_req = 1'b1;
        sb_q.push_back('{tag: "lbin_en", exp: 2});
        step();
        n_cmp++;
        if (lb_state !== 2'd1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL lbin_wgap got=%0d/%b exp=1/1", lb_state, busy);
        end
        run_switch(1'b0, wg, fl, fs, en_fl, moved, ffn);
        n_cmp++;
        if (wg !== GAP) begin
            n_bad++;
            $display("FAIL lbin_gap_len got=%0d exp=%0d", wg, GAP);
        end
        n_cmp++;
        if (fs !== FSH || fl !== FSH) begin
            n_bad++;
            $display("FAIL lbin_flush_len got=%0d/%0d exp=%0d", fs, fl, FSH);
        end
        n_cmp++;
        if (en_fl !== 1'b0 || moved !== 1'b0 || ffn !== 4'hA) begin
            n_bad++;
            $display("FAIL lbin_flsh_ctl got=%b%b %h exp=00 a", en_fl, moved, ffn);
        end
        e = sb_q.pop_front();
        n_cmp++;
        if (lb_state !== 2'd3 || {30'd0, uplbin, uplbout} !== e.exp) begin
            n_bad++;
            $display("FAIL %s got=%0d/%b%b exp=3/%0d", e.tag, lb_state, uplbin, uplbout, e.exp);
        end
        n_cmp++;
        if (fsh_in !== 1'b0 || busy !== 1'b0 || ffnum_out !== 4'hA) begin
            n_bad++;
            $display("FAIL lbin_act_ctl got=%b%b%h exp=00a", fsh_in, busy, ffnum_out);
        end
    endtask

    task automatic test_timeout();
        int         wg, fl, fs;
        bit         en_fl, moved;
        logic [3:0] ffn;
        sb_t        e;
        cfg_ffnum = 4'h5;
        lbin_req = 1'b0;
        lbout_req = 1'b1;
        sb_q.push_back('{tag: "lbout_en", exp: 1});
        step();
        run_switch(1'b1, wg, fl, fs, en_fl, moved, ffn);
        n_cmp++;
        if (wg !== TMO || moved !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_wait_len got=%0d/%b exp=%0d/0", wg, moved, TMO);
        end
        n_cmp++;
        if (tmo !== 1'b1) begin
            n_bad++;
            $display("FAIL tmo_sticky got=%b exp=1", tmo);
        end
        n_cmp++;
        if (fs !== FSH || en_fl !== 1'b0 || ffn !== 4'h5) begin
            n_bad++;
            $display("FAIL tmo_flush got=%0d/%b/%h exp=%0d/0/5", fs, en_fl, ffn, FSH);
        end
        e = sb_q.pop_front();
        n_cmp++;
        if (lb_state !== 2'd3 || {30'd0, uplbin, uplbout} !== e.exp) begin
            n_bad++;
            $display("FAIL %s got=%0d/%b%b exp=3/%0d", e.tag, lb_state, uplbin, uplbout, e.exp);
        end
    endtask

    task automatic test_conflict();
        int         wg, fl, fs;
        bit         en_fl, moved;
        logic [3:0] ffn;
        sb_t        e;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_cmp++;
        if (tmo !== 1'b0 || conflict !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_tmo got=%b%b exp=00", tmo, conflict);
        end
        lbin_req = 1'b1;
        lbout_req = 1'b1;
        sb_q.push_back('{tag: "conflict_en", exp: 2});
        step();
        run_switch(1'b0, wg, fl, fs, en_fl, moved, ffn);
        e = sb_q.pop_front();
        n_cmp++;
        if (lb_state !== 2'd3 || {30'd0, uplbin, uplbout} !== e.exp) begin
            n_bad++;
            $display("FAIL %s got=%0d/%b%b exp=3/%0d", e.tag, lb_state, uplbin, uplbout, e.exp);
        end
        n_cmp++;
        if (conflict !== 1'b1) begin
            n_bad++;
            $display("FAIL conflict_set got=%b exp=1", conflict);
        end
        lbout_req = 1'b0;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_cmp++;
        if (conflict !== 1'b0 || uplbin !== 1'b1) begin
            n_bad++;
            $display("FAIL conflict_clr got=%b/%b exp=0/1", conflict, uplbin);
        end
    endtask

    task automatic test_abort();
        bit saw_wgap = 1'b0;
        bit saw_fsh = 1'b0;
        bit lost_en = 1'b0;
        int k = 0;
        lbin_req = 1'b0;
        repeat (5) begin
            step();
            if (lb_state === 2'd1) saw_wgap = 1'b1;
            if (fsh_in !== 1'b0 || lb_state === 2'd2) saw_fsh = 1'b1;
            if (uplbin !== 1'b1) lost_en = 1'b1;
        end
        lbin_req = 1'b1;
        do begin
            step();
            k++;
            if (fsh_in !== 1'b0 || lb_state === 2'd2) saw_fsh = 1'b1;
            if (uplbin !== 1'b1) lost_en = 1'b1;
        end while (lb_state !== 2'd3 && k < 10);
        n_cmp++;
        if (saw_wgap !== 1'b1 || lb_state !== 2'd3) begin
            n_bad++;
            $display("FAIL abort_return got=%b/%0d exp=1/3", saw_wgap, lb_state);
        end
        n_cmp++;
        if (saw_fsh !== 1'b0 || lost_en !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_no_flush got=%b%b exp=00", saw_fsh, lost_en);
        end
    endtask

    task automatic test_flush();
        int         wg, fl, fs;
        bit         en_fl, moved;
        logic [3:0] ffn;
        cfg_ffnum = 4'h3;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        run_switch(1'b0, wg, fl, fs, en_fl, moved, ffn);
        n_cmp++;
        if (wg !== GAP || fs !== FSH || ffn !== 4'h3) begin
            n_bad++;
            $display("FAIL flush_seq got=%0d/%0d/%h exp=%0d/%0d/3", wg, fs, ffn, GAP, FSH);
        end
        n_cmp++;
        if (lb_state !== 2'd3 || uplbin !== 1'b1 || uplbout !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_mode got=%0d/%b%b exp=3/10", lb_state, uplbin, uplbout);
        end
    endtask

    task automatic test_errcnt();
        sb_t e;
        for (int i = 0; i < 300; i++) begin
            lbi_err = 1'b1;
            lbo_err = (i % 3) == 0;
            sb_q.push_back('{tag: "errcnt_lbi", exp: (i + 1 > 255) ? 255 : i + 1});
            sb_q.push_back('{tag: "errcnt_lbo", exp: (i / 3) + 1});
            step();
            e = sb_q.pop_front();
            n_cmp++;
            if ({24'd0, errcnt_lbi} !== e.exp) begin
                n_bad++;
                $display("FAIL %s[%0d] got=%0d exp=%0d", e.tag, i, errcnt_lbi, e.exp);
            end
            e = sb_q.pop_front();
            n_cmp++;
            if ({24'd0, errcnt_lbo} !== e.exp) begin
                n_bad++;
                $display("FAIL %s[%0d] got=%0d exp=%0d", e.tag, i, errcnt_lbo, e.exp);
            end
        end
        lbo_err = 1'b1;
        err_clr = 1'b1;
        sb_q.push_back('{tag: "errclr_wins", exp: 0});
        step();
        {lbi_err, lbo_err, err_clr} = '0;
        e = sb_q.pop_front();
        n_cmp++;
        if ({16'd0, errcnt_lbi, errcnt_lbo} !== e.exp) begin
            n_bad++;
            $display("FAIL %s got=%0d/%0d exp=0/0", e.tag, errcnt_lbi, errcnt_lbo);
        end
    endtask

    task automatic test_reset_in_flush();
        int k = 0;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        while (lb_state !== 2'd2 && k < 40) begin
            step();
            k++;
        end
        step();
        n_cmp++;
        if (lb_state !== 2'd2 || fsh_in !== 1'b1 || uplbin !== 1'b0) begin
            n_bad++;
            $display("FAIL flsh_second got=%0d/%b%b exp=2/10", lb_state, fsh_in, uplbin);
        end
        rst = 1'b1;
        lbin_req = 1'b0;
        step();
        n_cmp++;
        if ({lb_state, uplbin, uplbout, ffnum_in, ffnum_out, fsh_in, fsh_out, busy, conflict,
             tmo, errcnt_lbi, errcnt_lbo} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_flsh got=%0d/%b%b%b%b%b exp=0/00000", lb_state, uplbin,
                     uplbout, fsh_in, fsh_out, busy);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (lb_state !== 2'd0 || uplbin !== 1'b0) begin
            n_bad++;
            $display("FAIL post_rst_idle got=%0d/%b exp=0/0", lb_state, uplbin);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lbin_switch();
        test_timeout();
        test_conflict();
        test_abort();
        test_flush();
        test_errcnt();
        test_reset_in_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
